pcie_cq_mem_write_engine: RTL and testbench

- Consumes the PCIe Completer Request (CQ) AXI4-Stream (64-bit, DWORD-aligned descriptor mode) from the PCIe hard IP.
- Memory Write requests are unpacked and written one DWORD per cycle into a block-RAM write port.
- All other request types are consumed and dropped. The block sits between the PCIe IP and the BAR-mapped BRAM.

---
 rtl/pcie_cq_mem_write_engine_if.sv | 38 +++
 rtl/pcie_cq_mem_write_engine.sv | 228 ++++++++++++++++++++++
 tb/tb_pcie_cq_mem_write_engine.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_cq_mem_write_engine_if.sv
// CQ AXI4-Stream and BRAM write-port bundle for the CQ memory-write engine.
// slave = engine view (consumes CQ, drives BRAM); master = PCIe IP / BRAM side view.
interface pcie_cq_mem_write_engine_if #(
    parameter int unsigned PCIE_DATA_WIDTH     = 64,
    parameter int unsigned PCIE_KEEP_WIDTH     = 2,
    parameter int unsigned AXI4_CQ_TUSER_WIDTH = 88,
    parameter int unsigned BRAM_DATA_WIDTH     = 32,
    parameter int unsigned BRAM_ADDR_WIDTH     = 16,
    parameter int unsigned BRAM_KEEP_WIDTH     = 4
);
    logic [PCIE_DATA_WIDTH-1:0]     M_AXIS_CQ_TDATA;
    logic                           M_AXIS_CQ_TLAST;
    logic                           M_AXIS_CQ_TVALID;
    logic [AXI4_CQ_TUSER_WIDTH-1:0] M_AXIS_CQ_TUSER;
    logic [PCIE_KEEP_WIDTH-1:0]     M_AXIS_CQ_TKEEP;
    logic                           M_AXIS_CQ_TREADY;

    logic                           MEM_WR_BUSY;
    logic [BRAM_DATA_WIDTH-1:0]     MEM_WR_DATA;
    logic [BRAM_ADDR_WIDTH-1:0]     MEM_WR_ADDR;
    logic [BRAM_KEEP_WIDTH-1:0]     MEM_WR_KEEP;
    logic                           MEM_WR_LAST;
    logic                           MEM_WR_VALD;

    modport slave (
        input  M_AXIS_CQ_TDATA, M_AXIS_CQ_TLAST, M_AXIS_CQ_TVALID, M_AXIS_CQ_TUSER, M_AXIS_CQ_TKEEP,
        output M_AXIS_CQ_TREADY,
        input  MEM_WR_BUSY,
        output MEM_WR_DATA, MEM_WR_ADDR, MEM_WR_KEEP, MEM_WR_LAST, MEM_WR_VALD
    );

    modport master (
        output M_AXIS_CQ_TDATA, M_AXIS_CQ_TLAST, M_AXIS_CQ_TVALID, M_AXIS_CQ_TUSER, M_AXIS_CQ_TKEEP,
        input  M_AXIS_CQ_TREADY,
        output MEM_WR_BUSY,
        input  MEM_WR_DATA, MEM_WR_ADDR, MEM_WR_KEEP, MEM_WR_LAST, MEM_WR_VALD
    );
endinterface

// File: rtl/pcie_cq_mem_write_engine.sv
// Unpacks PCIe CQ Memory Write requests into one-DWORD-per-cycle BRAM writes; drops other requests.
// Optional CQ_DEBUG_EN: st_test = {PCIE_CQ_NP_REQ_COUNT[4:0], FSM state code}; otherwise st_test = 0.
module pcie_cq_mem_write_engine #(
    parameter int unsigned PCIE_DATA_WIDTH     = 64,
    parameter int unsigned PCIE_KEEP_WIDTH     = 2,
    parameter int unsigned AXI4_CQ_TUSER_WIDTH = 88,
    parameter int unsigned BRAM_DATA_WIDTH     = 32,
    parameter int unsigned BRAM_ADDR_WIDTH     = 16,
    parameter int unsigned BRAM_KEEP_WIDTH     = 4
) (
    input  logic                           CLK,
    input  logic                           RST,
    pcie_cq_mem_write_engine_if.slave      cq,
    input  logic [5:0]                     PCIE_CQ_NP_REQ_COUNT,
    output logic                           PCIE_CQ_NO_REQ,
    output logic [7:0]                     st_test
);
    localparam int unsigned CNT_W = 11;
    localparam int unsigned HI_W  = PCIE_DATA_WIDTH - BRAM_DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DESC    = 3'd1,
        S_DATA    = 3'd2,
        S_WR_LO   = 3'd3,
        S_WR_HI   = 3'd4,
        S_DISCARD = 3'd5
    } state_t;

    state_t                     state, state_nxt;
    logic [BRAM_ADDR_WIDTH-1:0] ptr, ptr_nxt;
    logic [CNT_W-1:0]           remaining, remaining_nxt;
    logic [BRAM_KEEP_WIDTH-1:0] first_be, first_be_nxt;
    logic [BRAM_KEEP_WIDTH-1:0] last_be, last_be_nxt;
    logic                       first_dw, first_dw_nxt;
    logic                       two_dw, two_dw_nxt;
    logic                       trunc, trunc_nxt;
    logic [HI_W-1:0]            data_hi, data_hi_nxt;
    logic                       tready, tready_nxt;
    logic                       no_req, no_req_nxt;
    logic [BRAM_DATA_WIDTH-1:0] wr_data, wr_data_nxt;
    logic [BRAM_ADDR_WIDTH-1:0] wr_addr, wr_addr_nxt;
    logic [BRAM_KEEP_WIDTH-1:0] wr_keep, wr_keep_nxt;
    logic                       wr_last, wr_last_nxt;
    logic                       wr_vald, wr_vald_nxt;

    logic                       beat_c, wr_xfer_c, sop_c, disc_c;
    logic [3:0]                 req_type_c;
    logic [CNT_W-1:0]           count_c;

    assign beat_c     = cq.M_AXIS_CQ_TVALID & tready;
    assign wr_xfer_c  = wr_vald & ~cq.MEM_WR_BUSY;
    assign sop_c      = cq.M_AXIS_CQ_TUSER[40];
    assign disc_c     = cq.M_AXIS_CQ_TUSER[41];
    assign count_c    = cq.M_AXIS_CQ_TDATA[10:0];
    assign req_type_c = cq.M_AXIS_CQ_TDATA[14:11];

    // Byte enables: first DWORD uses first_be (also covers count==1), final-by-count uses last_be.
    function automatic logic [BRAM_KEEP_WIDTH-1:0] dw_keep(
        input logic                       first,
        input logic [CNT_W-1:0]           rem,
        input logic [BRAM_KEEP_WIDTH-1:0] fbe,
        input logic [BRAM_KEEP_WIDTH-1:0] lbe
    );
        if (first)                  return fbe;
        else if (rem == CNT_W'(1))  return lbe;
        else                        return {BRAM_KEEP_WIDTH{1'b1}};
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            ptr       <= '0;
            remaining <= '0;
            first_be  <= '0;
            last_be   <= '0;
            first_dw  <= 1'b0;
            two_dw    <= 1'b0;
            trunc     <= 1'b0;
            data_hi   <= '0;
            tready    <= 1'b0;
            no_req    <= 1'b0;
            wr_data   <= '0;
            wr_addr   <= '0;
            wr_keep   <= '0;
            wr_last   <= 1'b0;
            wr_vald   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            remaining <= remaining_nxt;
            first_be  <= first_be_nxt;
            last_be   <= last_be_nxt;
            first_dw  <= first_dw_nxt;
            two_dw    <= two_dw_nxt;
            trunc     <= trunc_nxt;
            data_hi   <= data_hi_nxt;
            tready    <= tready_nxt;
            no_req    <= no_req_nxt;
            wr_data   <= wr_data_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_keep   <= wr_keep_nxt;
            wr_last   <= wr_last_nxt;
            wr_vald   <= wr_vald_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        remaining_nxt = remaining;
        first_be_nxt  = first_be;
        last_be_nxt   = last_be;
        first_dw_nxt  = first_dw;
        two_dw_nxt    = two_dw;
        trunc_nxt     = trunc;
        data_hi_nxt   = data_hi;
        no_req_nxt    = 1'b1;
        wr_data_nxt   = wr_data;
        wr_addr_nxt   = wr_addr;
        wr_keep_nxt   = wr_keep;
        wr_last_nxt   = wr_last;
        wr_vald_nxt   = wr_vald;

        case (state)
            S_IDLE: begin
                if (beat_c && sop_c) begin
                    ptr_nxt      = cq.M_AXIS_CQ_TDATA[BRAM_ADDR_WIDTH+1:2];
                    first_be_nxt = BRAM_KEEP_WIDTH'(cq.M_AXIS_CQ_TUSER[3:0]);
                    last_be_nxt  = BRAM_KEEP_WIDTH'(cq.M_AXIS_CQ_TUSER[7:4]);
                    state_nxt    = S_DESC;
                end
            end
            S_DESC: begin
                if (beat_c) begin
                    remaining_nxt = count_c;
                    first_dw_nxt  = 1'b1;
                    trunc_nxt     = 1'b0;
                    // A descriptor-only packet carries no payload, whatever its type.
                    if (cq.M_AXIS_CQ_TLAST)
                        state_nxt = S_IDLE;
                    else if (req_type_c == 4'b0001 && count_c != '0)
                        state_nxt = S_DATA;
                    else
                        state_nxt = S_DISCARD;
                end
            end
            S_DATA: begin
                if (beat_c) begin
                    if (disc_c) begin
                        state_nxt = cq.M_AXIS_CQ_TLAST ? S_IDLE : S_DISCARD;
                    end else begin
                        data_hi_nxt = cq.M_AXIS_CQ_TDATA[PCIE_DATA_WIDTH-1:BRAM_DATA_WIDTH];
                        two_dw_nxt  = (remaining > CNT_W'(1));
                        trunc_nxt   = cq.M_AXIS_CQ_TLAST;
                        wr_data_nxt = cq.M_AXIS_CQ_TDATA[BRAM_DATA_WIDTH-1:0];
                        wr_addr_nxt = ptr;
                        wr_keep_nxt = dw_keep(first_dw, remaining, first_be, last_be);
                        wr_last_nxt = (remaining == CNT_W'(1));
                        wr_vald_nxt = 1'b1;
                        state_nxt   = S_WR_LO;
                    end
                end
            end
            S_WR_LO: begin
                if (wr_xfer_c) begin
                    ptr_nxt       = ptr + BRAM_ADDR_WIDTH'(1);
                    remaining_nxt = remaining - CNT_W'(1);
                    first_dw_nxt  = 1'b0;
                    if (two_dw) begin
                        wr_data_nxt = data_hi;
                        wr_addr_nxt = ptr + BRAM_ADDR_WIDTH'(1);
                        wr_keep_nxt = dw_keep(1'b0, remaining - CNT_W'(1), first_be, last_be);
                        // Truncated packet: the upper DWORD of the TLAST beat closes the request.
                        wr_last_nxt = (remaining == CNT_W'(2)) | trunc;
                        state_nxt   = S_WR_HI;
                    end else begin
                        wr_vald_nxt = 1'b0;
                        wr_last_nxt = 1'b0;
                        state_nxt   = (trunc || remaining == CNT_W'(1)) ? S_IDLE : S_DATA;
                    end
                end
            end
            S_WR_HI: begin
                if (wr_xfer_c) begin
                    ptr_nxt       = ptr + BRAM_ADDR_WIDTH'(1);
                    remaining_nxt = remaining - CNT_W'(1);
                    wr_vald_nxt   = 1'b0;
                    wr_last_nxt   = 1'b0;
                    state_nxt     = (trunc || remaining == CNT_W'(1)) ? S_IDLE : S_DATA;
                end
            end
            S_DISCARD: begin
                if (beat_c && cq.M_AXIS_CQ_TLAST)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        tready_nxt = (state_nxt != S_WR_LO) && (state_nxt != S_WR_HI);
    end

    assign cq.M_AXIS_CQ_TREADY = tready;
    assign cq.MEM_WR_DATA      = wr_data;
    assign cq.MEM_WR_ADDR      = wr_addr;
    assign cq.MEM_WR_KEEP      = wr_keep;
    assign cq.MEM_WR_LAST      = wr_last;
    assign cq.MEM_WR_VALD      = wr_vald;
    assign PCIE_CQ_NO_REQ      = no_req;

`ifdef CQ_DEBUG_EN
    logic [7:0] st_q;
    always_ff @(posedge CLK) begin
        if (RST) st_q <= '0;
        else     st_q <= {PCIE_CQ_NP_REQ_COUNT[4:0], state_nxt};
    end
    assign st_test = st_q;
`else
    assign st_test = 8'h00;
`endif

    // Informational sideband and descriptor fields the write path does not need.
    logic [PCIE_KEEP_WIDTH-1:0] unused_keep;
    logic                       unused_inputs;
    assign unused_keep   = cq.M_AXIS_CQ_TKEEP;
    assign unused_inputs = ^{cq.M_AXIS_CQ_TUSER[AXI4_CQ_TUSER_WIDTH-1:42],
                             cq.M_AXIS_CQ_TUSER[39:8], PCIE_CQ_NP_REQ_COUNT};
endmodule

// File: tb/tb_pcie_cq_mem_write_engine.sv
// Directed bench for pcie_cq_mem_write_engine: packet table plus stall and reset sequences.
module tb_pcie_cq_mem_write_engine;
    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } wr_t;

    typedef struct {
        logic [63:0]       addr;
        logic [10:0]       count;
        logic [3:0]        rtype;
        logic [3:0]        fbe;
        logic [3:0]        lbe;
        int                nbeats;
        int                disc;
        logic [3:0][63:0]  beat;
        int                nwr;
        wr_t [5:0]         exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] np_req_count;
    logic       no_req;
    logic [7:0] st_test;

    int checks = 0;
    int errors = 0;
    int wait_sum = 0;
    int tready_viol = 0;
    wr_t wrq[$];
    vec_t vecs[8];

    pcie_cq_mem_write_engine_if bus();

    pcie_cq_mem_write_engine dut (
        .CLK                  (clk),
        .RST                  (rst),
        .cq                   (bus),
        .PCIE_CQ_NP_REQ_COUNT (np_req_count),
        .PCIE_CQ_NO_REQ       (no_req),
        .st_test              (st_test)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && bus.MEM_WR_VALD && !bus.MEM_WR_BUSY)
            wrq.push_back({bus.MEM_WR_ADDR, bus.MEM_WR_DATA, bus.MEM_WR_KEEP, bus.MEM_WR_LAST});
        if (!rst && bus.MEM_WR_VALD && bus.M_AXIS_CQ_TREADY)
            tready_viol++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic new_vec(input int i, input logic [63:0] a, input logic [10:0] c, input logic [3:0] rt,
                           input logic [3:0] fbe, input logic [3:0] lbe, input int nb, input int disc);
        vecs[i].addr = a;  vecs[i].count = c; vecs[i].rtype = rt;
        vecs[i].fbe = fbe; vecs[i].lbe = lbe; vecs[i].nbeats = nb; vecs[i].disc = disc;
        vecs[i].beat = '0; vecs[i].nwr = 0;   vecs[i].exp = '0;
    endtask

    task automatic add_wr(input int i, input logic [15:0] a, input logic [31:0] d, input logic [3:0] k, input logic l);
        wr_t w;
        w.a = a; w.d = d; w.k = k; w.l = l;
        vecs[i].exp[vecs[i].nwr] = w;
        vecs[i].nwr++;
    endtask

    // Present one beat from posedge+1, return at posedge+1 after it is accepted.
    task automatic send_beat(input logic [63:0] d, input logic [87:0] u, input logic l);
        int waited;
        bit acc;
        waited = 0;
        acc = 1'b0;
        bus.M_AXIS_CQ_TDATA  = d;
        bus.M_AXIS_CQ_TUSER  = u;
        bus.M_AXIS_CQ_TLAST  = l;
        bus.M_AXIS_CQ_TKEEP  = 2'b11;
        bus.M_AXIS_CQ_TVALID = 1'b1;
        while (!acc && waited < 64) begin
            @(negedge clk);
            if (bus.M_AXIS_CQ_TREADY) acc = 1'b1;
            else waited++;
        end
        if (acc) begin
            @(posedge clk);
            #1;
        end else begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got no TREADY after %0d cycles expected TREADY", waited);
        end
        wait_sum += waited;
        bus.M_AXIS_CQ_TVALID = 1'b0;
    endtask

    task automatic send_desc(input int i);
        logic [87:0] u;
        logic [63:0] d;
        u = '0;
        u[3:0] = vecs[i].fbe;
        u[7:4] = vecs[i].lbe;
        u[40]  = 1'b1;
        send_beat(vecs[i].addr, u, 1'b0);
        d = '0;
        d[10:0]  = vecs[i].count;
        d[14:11] = vecs[i].rtype;
        d[31:16] = 16'hBEEF;
        d[39:32] = 8'h5A;
        send_beat(d, 88'h0, vecs[i].nbeats == 0);
    endtask

    task automatic send_payload(input int i, input int b);
        logic [87:0] u;
        u = '0;
        u[41] = (b == vecs[i].disc);
        send_beat(vecs[i].beat[b], u, b == vecs[i].nbeats - 1);
    endtask

    task automatic send_pkt(input int i);
        send_desc(i);
        for (int b = 0; b < vecs[i].nbeats; b++) send_payload(i, b);
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic check_writes(input int i, input string tag);
        wr_t got;
        check($sformatf("%s num_writes", tag), 64'(wrq.size()), 64'(vecs[i].nwr));
        for (int j = 0; j < vecs[i].nwr; j++) begin
            if (j < wrq.size()) begin
                got = wrq[j];
                check($sformatf("%s wr%0d addr", tag, j), 64'(got.a), 64'(vecs[i].exp[j].a));
                check($sformatf("%s wr%0d data", tag, j), 64'(got.d), 64'(vecs[i].exp[j].d));
                check($sformatf("%s wr%0d keep", tag, j), 64'(got.k), 64'(vecs[i].exp[j].k));
                check($sformatf("%s wr%0d last", tag, j), 64'(got.l), 64'(vecs[i].exp[j].l));
            end
        end
    endtask

    // Holds MEM_WR_BUSY for 3 cycles once address 3 is presented.
    task automatic stall_at_addr3();
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk);
            #1;
            if (bus.MEM_WR_VALD && bus.MEM_WR_ADDR == 16'd3) seen = 1'b1;
            else n++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL stall_timeout: got no write to addr 3 expected one");
        end else begin
            bus.MEM_WR_BUSY = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(posedge clk);
                #1;
                check($sformatf("stall hold c%0d", c),
                      {bus.MEM_WR_VALD, bus.MEM_WR_ADDR, bus.MEM_WR_DATA, bus.MEM_WR_KEEP, bus.M_AXIS_CQ_TREADY},
                      {1'b1, 16'd3, 32'h0, 4'hF, 1'b0});
            end
            bus.MEM_WR_BUSY = 1'b0;
        end
    endtask

    initial begin
        new_vec(0, 64'h8, 11'd3, 4'b0001, 4'hF, 4'hF, 2, -1);
        vecs[0].beat[0] = 64'h0000_0000_0000_0123;
        vecs[0].beat[1] = 64'h0000_0000_0000_0456;
        add_wr(0, 16'd2, 32'h123, 4'hF, 1'b0);
        add_wr(0, 16'd3, 32'h0,   4'hF, 1'b0);
        add_wr(0, 16'd4, 32'h456, 4'hF, 1'b1);

        new_vec(1, 64'h8, 11'd3, 4'b0001, 4'hF, 4'hF, 2, 1);
        vecs[1].beat = vecs[0].beat;
        add_wr(1, 16'd2, 32'h123, 4'hF, 1'b0);
        add_wr(1, 16'd3, 32'h0,   4'hF, 1'b0);

        new_vec(2, 64'h40, 11'd4, 4'b0001, 4'hF, 4'hF, 2, 0);
        vecs[2].beat[0] = 64'h1111_2222_3333_4444;
        vecs[2].beat[1] = 64'h5555_6666_7777_8888;

        new_vec(3, 64'h80, 11'd2, 4'b0000, 4'hF, 4'hF, 0, -1);

        new_vec(4, 64'hC0, 11'd2, 4'b0010, 4'hF, 4'hF, 1, -1);
        vecs[4].beat[0] = 64'hCAFE_F00D_DEAD_BEEF;

        new_vec(5, 64'h20, 11'd1, 4'b0001, 4'h3, 4'h0, 1, -1);
        vecs[5].beat[0] = 64'hFFFF_FFFF_AABB_CCDD;
        add_wr(5, 16'd8, 32'hAABB_CCDD, 4'h3, 1'b1);

        new_vec(6, 64'h3FFF8, 11'd4, 4'b0001, 4'h1, 4'h8, 2, -1);
        vecs[6].beat[0] = 64'h2222_2222_1111_1111;
        vecs[6].beat[1] = 64'h4444_4444_3333_3333;
        add_wr(6, 16'hFFFE, 32'h1111_1111, 4'h1, 1'b0);
        add_wr(6, 16'hFFFF, 32'h2222_2222, 4'hF, 1'b0);
        add_wr(6, 16'h0000, 32'h3333_3333, 4'hF, 1'b0);
        add_wr(6, 16'h0001, 32'h4444_4444, 4'h8, 1'b1);

        new_vec(7, 64'h100, 11'd5, 4'b0001, 4'h7, 4'hE, 2, -1);
        vecs[7].beat[0] = 64'hB0B0_B0B0_A0A0_A0A0;
        vecs[7].beat[1] = 64'hD0D0_D0D0_C0C0_C0C0;
        add_wr(7, 16'h40, 32'hA0A0_A0A0, 4'h7, 1'b0);
        add_wr(7, 16'h41, 32'hB0B0_B0B0, 4'hF, 1'b0);
        add_wr(7, 16'h42, 32'hC0C0_C0C0, 4'hF, 1'b0);
        add_wr(7, 16'h43, 32'hD0D0_D0D0, 4'hF, 1'b1);

        rst = 1'b1;
        np_req_count = 6'd5;
        bus.M_AXIS_CQ_TDATA  = '0;
        bus.M_AXIS_CQ_TUSER  = '0;
        bus.M_AXIS_CQ_TLAST  = 1'b0;
        bus.M_AXIS_CQ_TKEEP  = '0;
        bus.M_AXIS_CQ_TVALID = 1'b0;
        bus.MEM_WR_BUSY      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset tready", 64'(bus.M_AXIS_CQ_TREADY), 64'd0);
        check("reset no_req", 64'(no_req), 64'd0);
        check("reset mem_wr", {bus.MEM_WR_VALD, bus.MEM_WR_LAST, bus.MEM_WR_KEEP, bus.MEM_WR_ADDR, bus.MEM_WR_DATA}, 64'd0);
        check("reset st_test", 64'(st_test), 64'd0);

        rst = 1'b0;
        @(posedge clk);
        #1;
        check("run no_req", 64'(no_req), 64'd1);
        check("idle tready", 64'(bus.M_AXIS_CQ_TREADY), 64'd1);

        // Stray non-sop beat in IDLE must be dropped.
        send_beat(64'h0000_0000_0000_0008, 88'h0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            wrq.delete();
            wait_sum = 0;
            send_pkt(i);
            check_writes(i, $sformatf("vec%0d", i));
            if (vecs[i].rtype != 4'b0001)
                check($sformatf("vec%0d tready_waits", i), 64'(wait_sum), 64'd0);
        end
        check("tready_low_while_writing", 64'(tready_viol), 64'd0);

        // BRAM stall on address 3.
        wrq.delete();
        fork
            send_pkt(0);
            stall_at_addr3();
        join
        check_writes(0, "stall");

        // Reset in the middle of the payload.
        wrq.delete();
        send_desc(6);
        send_payload(6, 0);
        check("pre_reset vald", 64'(bus.MEM_WR_VALD), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset outputs",
              {bus.M_AXIS_CQ_TREADY, no_req, bus.MEM_WR_VALD, bus.MEM_WR_LAST, bus.MEM_WR_KEEP, bus.MEM_WR_ADDR, bus.MEM_WR_DATA},
              64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("post_reset no_writes", 64'(wrq.size()), 64'd0);
        wrq.delete();
        send_pkt(7);
        check_writes(7, "after_reset");
`ifndef CQ_DEBUG_EN
        check("st_test tied", 64'(st_test), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
